// File: rtl/gpio_cfg_pkg.sv
// Shared definitions for the GPIO pad configuration sequencer: word bit map,
// reset configuration word and shifter FSM states.
package gpio_cfg_pkg;

  // Bit positions inside one pad configuration word
  typedef enum int unsigned {
    CfgDrive0   = 0,
    CfgDrive1   = 1,
    CfgSlew     = 2,
    CfgSchmitt  = 3,
    CfgPulldown = 4,
    CfgPullup   = 5,
    CfgInpDis   = 6,
    CfgHoldover = 7,
    CfgOutenb   = 8,
    CfgMgmtEna  = 9
  } cfg_bit_e;

  localparam int unsigned CfgWordW = 10;

  // Management-owned, output-disabled pad
  localparam logic [CfgWordW-1:0] CfgDefault =
      (CfgWordW'(1) << CfgMgmtEna) | (CfgWordW'(1) << CfgOutenb);

  typedef enum logic [2:0] {
    StIdle,
    StShiftLo,
    StShiftHi,
    StLoad,
    StDone
  } state_e;

endpackage

// File: rtl/gpio_cfg_sequencer_if.sv
// Register-bus and pad-chain signals of the GPIO configuration sequencer.
interface gpio_cfg_sequencer_if #(
  parameter int unsigned PADS = 38,
  parameter int unsigned WORD = 10
);
  localparam int unsigned AddrW = $clog2(PADS);

  logic             cfg_we;
  logic [AddrW-1:0] cfg_addr;
  logic [WORD-1:0]  cfg_wdata;
  logic [WORD-1:0]  cfg_rdata;
  logic             start;
  logic             busy;
  logic             done;
  logic             cfg_err;
  logic             serial_clock;
  logic             serial_data_out;
  logic             serial_load;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, start,
    input  cfg_rdata, busy, done, cfg_err, serial_clock, serial_data_out, serial_load
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, start,
    output cfg_rdata, busy, done, cfg_err, serial_clock, serial_data_out, serial_load
  );
endinterface

// File: rtl/gpio_cfg_shifter.sv
// Serial chain engine: clock divider, bit counter and serial pin generation.
// The parent supplies the stream bit selected by bit_idx.
module gpio_cfg_shifter
  import gpio_cfg_pkg::*;
#(
  parameter int unsigned PADS = 38,
  parameter int unsigned WORD = 10,
  parameter int unsigned DIV  = 2,
  localparam int unsigned BitW = $clog2(PADS * WORD)
) (
  input  logic            clock,
  input  logic            resetb,
  input  logic            start,
  output logic [BitW-1:0] bit_idx,
  input  logic            bit_val,
  output logic            busy,
  output logic            done,
  output logic            serial_clock,
  output logic            serial_data_out,
  output logic            serial_load
);

  localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(DIV - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(PADS * WORD - 1);

  state_e          state_q, state_d;
  logic [BitW-1:0] bit_q, bit_d;
  logic [DivW-1:0] div_q, div_d;
  logic            phase_end;

  assign phase_end = (div_q == DivLast);

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q <= StIdle;
      bit_q   <= '0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    div_d   = phase_end ? '0 : div_q + 1'b1;
    case (state_q)
      StIdle: begin
        div_d = '0;
        if (start) begin
          state_d = StShiftLo;
          bit_d   = '0;
        end
      end
      StShiftLo: if (phase_end) state_d = StShiftHi;
      StShiftHi: begin
        if (phase_end) begin
          bit_d   = bit_q + 1'b1;
          state_d = (bit_q == BitLast) ? StLoad : StShiftLo;
        end
      end
      StLoad:  if (phase_end) state_d = StDone;
      StDone: begin
        div_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bit_idx         = bit_q;
    busy            = (state_q != StIdle);
    done            = (state_q == StDone);
    serial_clock    = (state_q == StShiftHi);
    serial_load     = (state_q == StLoad);
    serial_data_out = ((state_q == StShiftLo) || (state_q == StShiftHi)) && bit_val;
  end

endmodule

// File: rtl/gpio_cfg_sequencer.sv
// GPIO pad configuration sequencer: per-pad register file plus serial chain shifter.
// Define GPIO_CFG_READBACK_EN to enable cfg_rdata readback; otherwise it reads 0.
module gpio_cfg_sequencer
  import gpio_cfg_pkg::*;
#(
  parameter int unsigned     PADS        = 38,
  parameter int unsigned     WORD        = CfgWordW,
  parameter int unsigned     DIV         = 2,
  parameter logic [WORD-1:0] DEFAULT_CFG = WORD'(CfgDefault)
) (
  input logic               clock,
  input logic               resetb,
  gpio_cfg_sequencer_if.slave bus
);

  localparam int unsigned AddrW = $clog2(PADS);
  localparam int unsigned Total = PADS * WORD;
  localparam int unsigned BitW  = $clog2(Total);
  localparam logic [AddrW-1:0] LastPad = AddrW'(PADS - 1);
  localparam logic [BitW-1:0]  BitLast = BitW'(Total - 1);

  logic [WORD-1:0]  regs_q [PADS];
  logic [Total-1:0] flat;
  logic [BitW-1:0]  bit_idx;
  logic [BitW-1:0]  rev_idx;
  logic             busy;
  logic             addr_ok;
  logic             wr_ok;
  logic             start_ok;
  logic             err_q;

  assign addr_ok  = (bus.cfg_addr <= LastPad);
  assign wr_ok    = bus.cfg_we && !busy && addr_ok;
  assign start_ok = bus.start && !busy;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      for (int p = 0; p < PADS; p++) regs_q[p] <= DEFAULT_CFG;
      err_q <= 1'b0;
    end else begin
      if (wr_ok) regs_q[bus.cfg_addr] <= bus.cfg_wdata;
      err_q <= (bus.cfg_we && (busy || !addr_ok)) || (bus.start && busy);
    end
  end

  // Pad 0 sits at the bottom of the flat vector so stream bit n is flat[Total-1-n]
  always_comb begin
    flat = '0;
    for (int p = 0; p < PADS; p++) flat[p*WORD +: WORD] = regs_q[p];
  end

  assign rev_idx     = BitLast - bit_idx;
  assign bus.cfg_err = err_q;
  assign bus.busy    = busy;

`ifdef GPIO_CFG_READBACK_EN
  assign bus.cfg_rdata = addr_ok ? regs_q[bus.cfg_addr] : '0;
`else
  assign bus.cfg_rdata = '0;
`endif

  gpio_cfg_shifter #(
    .PADS (PADS),
    .WORD (WORD),
    .DIV  (DIV)
  ) u_shifter (
    .clock           (clock),
    .resetb          (resetb),
    .start           (start_ok),
    .bit_idx         (bit_idx),
    .bit_val         (flat[rev_idx]),
    .busy            (busy),
    .done            (bus.done),
    .serial_clock    (bus.serial_clock),
    .serial_data_out (bus.serial_data_out),
    .serial_load     (bus.serial_load)
  );

endmodule

// File: tb/tb_gpio_cfg_sequencer.sv
// Scoreboard bench for gpio_cfg_sequencer: expected chain bits are queued at start
// and popped on every rising serial_clock.
module tb_gpio_cfg_sequencer;
  localparam int unsigned PADS  = 38;
  localparam int unsigned WORD  = 10;
  localparam int unsigned DIV   = 2;
  localparam int unsigned NBITS = PADS * WORD;
  localparam int unsigned BUSY_LEN = 2 * DIV * PADS * WORD + DIV + 1;
  localparam logic [9:0] DEF = 10'h300;

  logic clock  = 1'b0;
  logic resetb = 1'b0;

  gpio_cfg_sequencer_if #(.PADS(PADS), .WORD(WORD)) bus ();

  gpio_cfg_sequencer #(
    .PADS        (PADS),
    .WORD        (WORD),
    .DIV         (DIV),
    .DEFAULT_CFG (DEF)
  ) dut (
    .clock  (clock),
    .resetb (resetb),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  logic [9:0] mdl [PADS];
  bit   exp_q [$];

  int rises = 0, loads = 0, errs = 0;
  logic prev_sclk = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!resetb) begin
      prev_sclk <= 1'b0;
    end else begin
      if (bus.serial_clock && !prev_sclk) begin
        rises = rises + 1;
        if (exp_q.size() == 0) check_eq("stream_extra_bit", 32'd1, 32'd0);
        else check_eq("stream_bit", {31'd0, bus.serial_data_out}, {31'd0, exp_q.pop_front()});
      end
      if (bus.serial_load) loads = loads + 1;
      if (bus.cfg_err) errs = errs + 1;
      prev_sclk <= bus.serial_clock;
    end
  end

  task automatic push_stream();
    for (int n = 0; n < NBITS; n++) begin
      logic [9:0] w;
      w = mdl[PADS - 1 - n / WORD];
      exp_q.push_back(w[WORD - 1 - n % WORD]);
    end
  endtask

  task automatic cfg_write(input logic [5:0] addr, input logic [9:0] data);
    @(negedge clock);
    bus.cfg_we = 1'b1; bus.cfg_addr = addr; bus.cfg_wdata = data;
    if (addr < PADS) mdl[addr] = data;
    @(negedge clock);
    bus.cfg_we = 1'b0;
  endtask

  task automatic check_readback();
`ifdef GPIO_CFG_READBACK_EN
    for (int p = 0; p < PADS; p++) begin
      bus.cfg_addr = 6'(p);
      #1 check_eq("readback", {22'd0, bus.cfg_rdata}, {22'd0, mdl[p]});
    end
`else
    bus.cfg_addr = 6'd5;
    #1 check_eq("readback_tied0", {22'd0, bus.cfg_rdata}, 32'd0);
`endif
  endtask

  // Full transfer; s_at/w_at inject a start/write at that busy cycle (0 = none)
  task automatic xfer(input bit same_wr, input logic [5:0] wa, input logic [9:0] wd,
                      input int s_at, input int w_at, input int exp_err);
    int n, done_at, r0, l0, e0;
    @(negedge clock);
    if (same_wr) begin
      bus.cfg_we = 1'b1; bus.cfg_addr = wa; bus.cfg_wdata = wd;
      mdl[wa] = wd;
    end
    push_stream();
    r0 = rises; l0 = loads; e0 = errs;
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0; bus.cfg_we = 1'b0;
    check_eq("busy_after_start", {31'd0, bus.busy}, 32'd1);
    n = 0; done_at = 0;
    while (bus.busy && n < 4000) begin
      if (bus.done) done_at = n + 1;
      bus.start  = (s_at != 0 && n == s_at);
      bus.cfg_we = (w_at != 0 && n == w_at);
      bus.cfg_addr = 6'd3; bus.cfg_wdata = 10'h0FF;
      n++;
      @(negedge clock);
    end
    bus.start = 1'b0; bus.cfg_we = 1'b0;
    @(negedge clock);
    check_eq("busy_length", n, BUSY_LEN);
    check_eq("done_cycle", done_at, BUSY_LEN);
    check_eq("sclk_rises", rises - r0, NBITS);
    check_eq("load_cycles", loads - l0, DIV);
    check_eq("err_pulses", errs - e0, exp_err);
    check_eq("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    int e0, l0;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0; bus.start = 1'b0;
    for (int p = 0; p < PADS; p++) mdl[p] = DEF;
    repeat (3) @(negedge clock);
    resetb = 1'b1;
    @(negedge clock);

    check_eq("rst_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("rst_done", {31'd0, bus.done}, 32'd0);
    check_eq("rst_err", {31'd0, bus.cfg_err}, 32'd0);
    check_eq("rst_sclk", {31'd0, bus.serial_clock}, 32'd0);
    check_eq("rst_sdo", {31'd0, bus.serial_data_out}, 32'd0);
    check_eq("rst_load", {31'd0, bus.serial_load}, 32'd0);
    check_readback();

    xfer(1'b0, 6'd0, 10'd0, 0, 0, 0);

    e0 = errs;
    for (int p = 1; p < PADS - 1; p++) cfg_write(6'(p), 10'($urandom));
    cfg_write(6'd0, 10'h2A5);
    cfg_write(6'd37, 10'h15A);
    @(negedge clock);
    check_eq("inrange_write_err", errs - e0, 0);
    e0 = errs;
    cfg_write(6'd40, 10'h3FF);
    @(negedge clock);
    check_eq("oob_write_err", errs - e0, 1);
    check_readback();
    xfer(1'b0, 6'd0, 10'd0, 0, 0, 0);

    xfer(1'b0, 6'd0, 10'd0, 100, 200, 2);
    check_readback();

    xfer(1'b1, 6'd5, 10'h3C3, 0, 0, 0);
    check_readback();

    // Abort a transfer with reset and confirm defaults come back
    cfg_write(6'd7, 10'h011);
    @(negedge clock);
    push_stream();
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (300) @(negedge clock);
    l0 = loads;
    #2 resetb = 1'b0;
    #1;
    check_eq("abort_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("abort_sclk", {31'd0, bus.serial_clock}, 32'd0);
    check_eq("abort_sdo", {31'd0, bus.serial_data_out}, 32'd0);
    check_eq("abort_load", {31'd0, bus.serial_load}, 32'd0);
    check_eq("abort_done", {31'd0, bus.done}, 32'd0);
    repeat (3) @(negedge clock);
    exp_q.delete();
    for (int p = 0; p < PADS; p++) mdl[p] = DEF;
    resetb = 1'b1;
    repeat (2) @(negedge clock);
    check_eq("abort_no_load", loads - l0, 0);
    check_readback();
    xfer(1'b0, 6'd0, 10'd0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
